// File: rtl/digital_input_capture_pkg.sv
// Shared definitions for digital_input_capture: readback selector
// encodings and the peripheral data bus width.
package digital_input_capture_pkg;

  // Peripheral data bus width (dataIn / dataOut)
  localparam int DATA_W = 32;

  // readSelect encodings for the dataOut readback mux
  localparam logic [1:0] SEL_LEVEL   = 2'd0;
  localparam logic [1:0] SEL_STATUS  = 2'd1;
  localparam logic [1:0] SEL_RISE_EN = 2'd2;
  localparam logic [1:0] SEL_FALL_EN = 2'd3;

endpackage

// File: rtl/digital_input_capture_debouncer.sv
// input_debouncer: single-pin filter. The output follows the input only
// after the input has differed from the output for CYCLES consecutive
// clocks; any return to equality restarts the count. Used by
// digital_input_capture only when DIGITAL_INPUT_DEBOUNCE_EN is defined.
module input_debouncer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  // The change is accepted on the clock where the count would reach CYCLES,
  // which makes the added latency exactly CYCLES clocks.
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count consecutive cycles of disagreement; commit the new value on the last one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      out <= 1'b0;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      out <= in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digital_input_capture.sv
// digital_input_capture: synchronizes up to 32 input pins, detects rising
// and falling edges per pin, latches enabled edges into a write-1-to-clear
// status register and drives a level interrupt (OR of status).
// Optional per-pin debounce filter: define DIGITAL_INPUT_DEBOUNCE_EN.
//
// Bus handshake: there is no valid/ready pair; a write strobe takes effect
// on the clock edge where chipSelect and the strobe are both high, and
// dataOut is a pure combinational function of readSelect and register state.
module digital_input_capture
  import digital_input_capture_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chipSelect,
  input  logic              writeRiseEnable,
  input  logic              writeFallEnable,
  input  logic              writeClear,
  input  logic [1:0]        readSelect,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  input  logic [WIDTH-1:0]  pins,
  output logic              irq
);

  // Elaboration-time parameter sanity checks
  if (WIDTH < 1 || WIDTH > DATA_W) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr_mask;

  // Bits of dataIn above WIDTH are ignored
  assign wdata = dataIn[WIDTH-1:0];

  // Synchronizer chain: stage 0 samples the asynchronous pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef DIGITAL_INPUT_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    input_debouncer #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk (clk),
      .rst (rst),
      .in  (sync_q[SYNC_STAGES-1][i]),
      .out (level[i])
    );
  end
`else
  assign level = sync_q[SYNC_STAGES-1];
`endif

  // Enabled edges that set status this cycle; clear mask from a W1C write
  assign edge_set = (level & ~prev & rise_en) | (~level & prev & fall_en);
  assign clr_mask = (chipSelect && writeClear) ? wdata : '0;

  // prev always follows level so a newly enabled, already-high pin is silent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  // Enable registers; both strobes may load the same dataIn in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_en <= '0;
      fall_en <= '0;
    end else begin
      if (chipSelect && writeRiseEnable) rise_en <= wdata;
      if (chipSelect && writeFallEnable) fall_en <= wdata;
    end
  end

  // Sticky status with W1C; a simultaneous set wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= '0;
    else     status <= (status & ~clr_mask) | edge_set;
  end

  assign irq = |status;

  // Readback mux; bits above WIDTH read as zero
  always_comb begin
    dataOut = '0;
    case (readSelect)
      SEL_LEVEL:   dataOut[WIDTH-1:0] = level;
      SEL_STATUS:  dataOut[WIDTH-1:0] = status;
      SEL_RISE_EN: dataOut[WIDTH-1:0] = rise_en;
      SEL_FALL_EN: dataOut[WIDTH-1:0] = fall_en;
      default:     dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_digital_input_capture.sv
// Self-checking bench for digital_input_capture (WIDTH=32, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). Honours DIGITAL_INPUT_DEBOUNCE_EN if defined.
module tb_digital_input_capture;
  import digital_input_capture_pkg::*;

  localparam int S = 2;
  localparam int D = 4;
`ifdef DIGITAL_INPUT_DEBOUNCE_EN
  localparam int DEB = 1;
  localparam int LAT = S + 1 + D;
`else
  localparam int DEB = 0;
  localparam int LAT = S + 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chipSelect = 1'b0;
  logic        writeRiseEnable = 1'b0;
  logic        writeFallEnable = 1'b0;
  logic        writeClear = 1'b0;
  logic [1:0]  readSelect = 2'd0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic [31:0] pins = '0;
  logic        irq;

  always #10 clk = ~clk;

  digital_input_capture #(
    .WIDTH(32), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst(rst), .chipSelect(chipSelect),
    .writeRiseEnable(writeRiseEnable), .writeFallEnable(writeFallEnable),
    .writeClear(writeClear), .readSelect(readSelect), .dataIn(dataIn),
    .dataOut(dataOut), .pins(pins), .irq(irq)
  );

  int total = 0;
  int bad = 0;

  // ---------------- behavioural model ----------------
  logic [31:0] pin_hist[$];
  logic [31:0] m_lvl, m_prv, m_st, m_re, m_fe;
  int          m_cnt[32];

  task automatic model_reset();
    pin_hist = {};
    for (int i = 0; i < S; i++) pin_hist.push_back(32'h0);
    m_lvl = '0; m_prv = '0; m_st = '0; m_re = '0; m_fe = '0;
    for (int b = 0; b < 32; b++) m_cnt[b] = 0;
  endtask

  task automatic model_step();
    logic [31:0] old_sync, new_sync, set;
    old_sync = pin_hist[S-1];
    pin_hist.push_front(pins);
    void'(pin_hist.pop_back());
    new_sync = pin_hist[S-1];
    set = (m_lvl & ~m_prv & m_re) | (~m_lvl & m_prv & m_fe);
    if (chipSelect && writeClear) m_st = m_st & ~dataIn;
    m_st = m_st | set;
    if (chipSelect && writeRiseEnable) m_re = dataIn;
    if (chipSelect && writeFallEnable) m_fe = dataIn;
    m_prv = m_lvl;
    if (DEB == 0) begin
      m_lvl = new_sync;
    end else begin
      for (int b = 0; b < 32; b++) begin
        if (old_sync[b] != m_lvl[b]) begin
          if (m_cnt[b] == D - 1) begin
            m_lvl[b] = old_sync[b];
            m_cnt[b] = 0;
          end else begin
            m_cnt[b] = m_cnt[b] + 1;
          end
        end else begin
          m_cnt[b] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Sweep all readback sources and irq against the model
  task automatic check_all();
    logic [1:0] keep;
    keep = readSelect;
    exp_q = {m_lvl, m_st, m_re, m_fe};
    for (int s = 0; s < 4; s++) begin
      readSelect = 2'(s);
      #1;
      compare($sformatf("model_sel%0d", s), dataOut, exp_q.pop_front());
    end
    compare("model_irq", {31'h0, irq}, {31'h0, |m_st});
    readSelect = keep;
  endtask

  task automatic expect_reg(input string name, input logic [1:0] sel, input logic [31:0] val);
    readSelect = sel;
    #1;
    compare(name, dataOut, val);
  endtask

  task automatic expect_irq(input string name, input logic val);
    #1;
    compare(name, {31'h0, irq}, {31'h0, val});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input logic re_s, input logic fe_s, input logic clr_s, input logic [31:0] d);
    chipSelect = 1'b1; writeRiseEnable = re_s; writeFallEnable = fe_s;
    writeClear = clr_s; dataIn = d;
    cycle();
    chipSelect = 1'b0; writeRiseEnable = 1'b0; writeFallEnable = 1'b0;
    writeClear = 1'b0; dataIn = $urandom;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cycle();

    // reset state
    expect_reg("rst_level", SEL_LEVEL, 32'h0);
    expect_reg("rst_status", SEL_STATUS, 32'h0);
    expect_reg("rst_rise_en", SEL_RISE_EN, 32'h0);
    expect_reg("rst_fall_en", SEL_FALL_EN, 32'h0);
    expect_irq("rst_irq", 1'b0);

    // rising edges on enabled pins 0 and 2
    wr(1'b1, 1'b0, 1'b0, 32'h5);
    pins = 32'h7;
    repeat (LAT - 1) cycle();
    expect_reg("rise_early", SEL_STATUS, 32'h0);
    cycle();
    expect_reg("rise_status", SEL_STATUS, 32'h5);
    expect_irq("rise_irq", 1'b1);
    expect_reg("rise_level", SEL_LEVEL, 32'h7);
    wr(1'b0, 1'b0, 1'b1, 32'h1);
    expect_reg("clr1_status", SEL_STATUS, 32'h4);
    wr(1'b0, 1'b0, 1'b1, 32'h4);
    expect_reg("clr4_status", SEL_STATUS, 32'h0);
    expect_irq("clr4_irq", 1'b0);

    // write without chipSelect is ignored
    writeRiseEnable = 1'b1; dataIn = 32'hdead_beef;
    cycle();
    writeRiseEnable = 1'b0;
    expect_reg("nocs_rise_en", SEL_RISE_EN, 32'h5);

    // falling edge on pin 31; rising edge on pin 31 ignored
    wr(1'b0, 1'b1, 1'b0, 32'h8000_0000);
    pins = 32'h8000_0000;
    repeat (LAT) cycle();
    expect_reg("fall_pre", SEL_STATUS, 32'h0);
    pins = 32'h0;
    repeat (LAT) cycle();
    expect_reg("fall_status", SEL_STATUS, 32'h8000_0000);
    pins = 32'h8000_0000;
    repeat (LAT) cycle();
    expect_reg("fall_rise_ignored", SEL_STATUS, 32'h8000_0000);
    wr(1'b0, 1'b0, 1'b1, 32'h8000_0000);
    expect_reg("fall_clr", SEL_STATUS, 32'h0);

    // edge and W1C of the same bit in the same cycle: set wins
    wr(1'b1, 1'b0, 1'b0, 32'h8);
    pins = 32'h8000_0008;
    repeat (LAT - 1) cycle();
    wr(1'b0, 1'b0, 1'b1, 32'h8);
    expect_reg("set_wins", SEL_STATUS, 32'h8);
    wr(1'b0, 1'b0, 1'b1, 32'h8);
    expect_reg("set_wins_clr", SEL_STATUS, 32'h0);

    // enables off, pins toggle; then enable while pins already high
    wr(1'b1, 1'b1, 1'b0, 32'h0);
    expect_reg("both_en_re", SEL_RISE_EN, 32'h0);
    expect_reg("both_en_fe", SEL_FALL_EN, 32'h0);
    pins = 32'h0;
    repeat (LAT) cycle();
    pins = 32'h0000_FFFF;
    repeat (LAT) cycle();
    expect_reg("noen_status", SEL_STATUS, 32'h0);
    expect_reg("noen_level", SEL_LEVEL, 32'h0000_FFFF);
    wr(1'b1, 1'b0, 1'b0, 32'h0000_FFFF);
    repeat (LAT) cycle();
    expect_reg("en_high_status", SEL_STATUS, 32'h0);

`ifdef DIGITAL_INPUT_DEBOUNCE_EN
    // short pulse rejected, long pulse accepted after LAT cycles
    wr(1'b1, 1'b0, 1'b0, 32'h1);
    pins = 32'h0;
    repeat (LAT) cycle();
    wr(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    pins = 32'h1;
    repeat (3) cycle();
    pins = 32'h0;
    repeat (LAT + 2) cycle();
    expect_reg("deb_short", SEL_STATUS, 32'h0);
    pins = 32'h1;
    repeat (LAT - 1) cycle();
    expect_reg("deb_long_early", SEL_STATUS, 32'h0);
    cycle();
    expect_reg("deb_long", SEL_STATUS, 32'h1);
`endif

    // asynchronous reset mid-cycle while status = 0x1
    wr(1'b1, 1'b0, 1'b0, 32'h1);
    wr(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    pins = 32'h0;
    repeat (LAT) cycle();
    pins = 32'h1;
    repeat (LAT) cycle();
    expect_reg("pre_rst_status", SEL_STATUS, 32'h1);
    @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    compare("async_rst_status_now", {31'h0, irq}, 32'h0);
    expect_reg("async_rst_status", SEL_STATUS, 32'h0);
    expect_reg("async_rst_level", SEL_LEVEL, 32'h0);
    expect_reg("async_rst_re", SEL_RISE_EN, 32'h0);
    expect_reg("async_rst_fe", SEL_FALL_EN, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // randomized traffic checked every cycle against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) pins = $urandom;
      chipSelect      = 1'($urandom_range(0, 1));
      writeRiseEnable = ($urandom_range(0, 7) == 0);
      writeFallEnable = ($urandom_range(0, 7) == 0);
      writeClear      = ($urandom_range(0, 3) == 0);
      dataIn          = $urandom;
      readSelect      = 2'($urandom_range(0, 3));
      cycle();
    end
    chipSelect = 1'b0; writeRiseEnable = 1'b0; writeFallEnable = 1'b0; writeClear = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digital_input_capture.md
# digital_input_capture

Input-side companion to the bidirectional digital port. Samples up to 32 FPGA input pins through a synchronizer and detects rising and falling edges per pin. Latches detected edges into a write-1-to-clear status register and raises a level interrupt for the CPU. Sits on the same peripheral bus as the port: chip select, write strobes, 32-bit data in/out.

## Interface
- `WIDTH`, 32: number of input pins, 1..32.
- `SYNC_STAGES`, 2: synchronizer flops per pin, minimum 2.
- `DEBOUNCE_CYCLES`, 16: stable cycles required before a pin change is accepted. Used only with the debounce macro; minimum 1.

- `clk`  in  1: single clock; all state on posedge.
- `rst`  in  1: reset, asynchronous, active-high.
- `chipSelect`  in  1: qualifies all write strobes.
- `writeRiseEnable`  in  1: load rise-enable register from `dataIn`.
- `writeFallEnable`  in  1: load fall-enable register from `dataIn`.
- `writeClear`  in  1: clear status bits where `dataIn` bit is 1.
- `readSelect`  in  2: selects the readback source.
  - 0: filtered pin value
  - 1: status
  - 2: rise enable
  - 3: fall enable
- `dataIn`  in  32: write data; bits ≥ WIDTH ignored.
- `dataOut`  out  32: combinational readback mux, independent of `chipSelect`. Bits ≥ WIDTH read 0.
- `pins`  in  WIDTH: asynchronous FPGA pins.
- `irq`  out  1: OR-reduction of the status register.

## Operation
- Pipeline per pin: `pins` → sync chain → optional debounce → `level` → `prev` (`level` delayed 1 cycle).
- Edge terms:
  - `rise = level & ~prev`
  - `fall = ~level & prev`
- Status bit set by `(rise & riseEn) | (fall & fallEn)`. It stays set until cleared.
- W1C: on `chipSelect & writeClear`, clear status bits where `dataIn` bit = 1.
- Set and clear of the same bit in the same cycle: set wins, so no event is lost.
- Enable registers load on `chipSelect & writeRiseEnable` / `writeFallEnable`. Both strobes may fire in the same cycle and load the same `dataIn`.
- Clearing an enable does not clear an already-set status bit.
- Writes with `chipSelect` low have no effect.
- `prev` tracks `level` at all times, whatever the enables. Enabling a pin that is already high therefore produces no event.
- Reset (asynchronous, any time, including mid-edge) forces to 0:
  - sync chain, debounce state, `level`, `prev`
  - enables, status, `irq`
  - `dataOut` then reads 0 for every `readSelect`.

## Timing
- A pin change settling before posedge k appears in `level` (readSelect 0) after posedge k+SYNC_STAGES−1. Debounce adds cycles; see Configuration.
- Status bit and `irq` rise after posedge k+SYNC_STAGES. That is 2 cycles for the default.
- `irq` is combinational from status: zero added latency, no glitch beyond status register transitions.
- W1C write at posedge n: status and `irq` drop after posedge n, unless a new enabled edge sets the bit in the same cycle.
- Enable write at posedge n governs edge detection from the cycle after posedge n.
- Pulses shorter than one clock period may be missed. This is acceptable and not flagged.

## Configuration
- `DIGITAL_INPUT_DEBOUNCE_EN` defined:
  - A per-pin counter, `$clog2(DEBOUNCE_CYCLES+1)` bits, sits between the sync output and `level`.
  - While the sync output equals `level`, the counter is 0.
  - While it differs, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES, `level` takes the sync value and the counter returns to 0.
  - A bounce back to equal resets the counter.
  - Added latency: DEBOUNCE_CYCLES cycles.
- Undefined: `level` is the last sync stage directly. No counters are instantiated and the parameter is ignored.

## Structure
- Shared package holds:
  - readSelect encodings: `SEL_LEVEL`=0, `SEL_STATUS`=1, `SEL_RISE_EN`=2, `SEL_FALL_EN`=3
  - data bus width constant (32)
- One sub-module, `input_debouncer`: single-pin filter with clk, rst, in, out and parameter CYCLES. Instantiated WIDTH times in a generate loop, only under the macro.
- Sync chain, edge logic, registers and mux stay in the top module.

## Test plan
- Reset → `dataOut`=0 for all four selects, `irq`=0. Pulse `rst` asynchronously mid-cycle while status=0x1 → status and `irq` drop immediately.
- riseEn=0x00000005; drive pins 0x0 → 0x7 → status reads 0x5 two cycles later (no debounce), `irq`=1. Write clear 0x1 → status 0x4. Write clear 0x4 → `irq`=0.
- fallEn=0x80000000; pin 31 goes 1 → 0 → status bit 31 set. Pin 31 goes 0 → 1 → no change.
- Pin 3 rising edge lands in the same cycle as W1C of bit 3 (riseEn bit 3 = 1) → status bit 3 remains 1.
- Enables = 0, pins toggle 0xFFFF → status stays 0 and readSelect 0 reads 0xFFFF. Then riseEn=0xFFFF with pins held high → no status bits set.
- With `DIGITAL_INPUT_DEBOUNCE_EN`, DEBOUNCE_CYCLES=4, riseEn=0x1:
  - pin 0 high for 3 cycles then low → no event
  - pin 0 high for 10 cycles → status 0x1 exactly 4 cycles later than the non-debounced build.
